// File: rtl/dcache_defs.sv
// Shared field layout, widths and FSM encoding for the MEM-stage data cache.
package dcache_defs;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned NUM_LINES  = 16;
    localparam int unsigned INDEX_W    = 4;
    localparam int unsigned OFFSET_W   = 5;
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_BITS  = 256;
    localparam int unsigned WORD_SEL_W = 3;
    localparam int unsigned BYTE_W     = 2;

    // Byte address as seen by the cache: tag [31:9], index [8:5], word [4:2].
    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [INDEX_W-1:0]    index;
        logic [WORD_SEL_W-1:0] word;
        logic [BYTE_W-1:0]     byte_off;
    } addr_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: async read, sync line refill or word merge,
// async clear of valid/dirty.
module dcache_sram
    import dcache_defs::*;
(
    input  logic                  clk_i,
    input  logic                  start_i,
    input  logic [INDEX_W-1:0]    idx_i,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [LINE_BITS-1:0]  line_o,
    input  logic                  line_we_i,
    input  logic [TAG_W-1:0]      line_tag_i,
    input  logic [LINE_BITS-1:0]  line_data_i,
    input  logic                  word_we_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]     word_data_i
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    // A refill leaves the line clean; a store hit marks it dirty.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (line_we_i) begin
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
        end else if (word_we_i) begin
            dirty_d[idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Payload arrays carry no reset; contents are meaningless until valid.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= line_tag_i;
            data_q[idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_sel_i, 5'd0} +: WORD_W] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller: hit logic,
// pipeline stall and the line-wide memory interface.
module dcache_controller
    import dcache_defs::*;
(
    input  logic                 clk_i,
    input  logic                 start_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [WORD_W-1:0]    cpu_data_i,
    output logic [WORD_W-1:0]    cpu_data_o,
    output logic                 cpu_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o
);

    state_e               state_q, state_d;
    logic                 mem_enable_q, mem_enable_d;
    logic                 mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;
    logic [TAG_W-1:0]     req_tag_q, req_tag_d;
    logic [INDEX_W-1:0]   req_idx_q, req_idx_d;

    addr_t                addr_c;
    logic [BYTE_W-1:0]    unused_byte_c;
    logic [INDEX_W-1:0]   sram_idx_c;
    logic                 sram_valid, sram_dirty;
    logic [TAG_W-1:0]     sram_tag;
    logic [LINE_BITS-1:0] sram_line;
    logic                 req_c, hit_c, miss_c, line_we_c, word_we_c;

    assign addr_c        = cpu_addr_i;
    assign unused_byte_c = addr_c.byte_off;

    // While a miss is in flight the captured index addresses the arrays.
    assign sram_idx_c = (state_q == IDLE) ? addr_c.index : req_idx_q;

    assign req_c       = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit_c       = req_c & sram_valid & (sram_tag == addr_c.tag) & (state_q == IDLE);
    assign miss_c      = req_c & ~hit_c;
    assign cpu_stall_o = miss_c;
    assign cpu_data_o  = hit_c ? sram_line[{addr_c.word, 5'd0} +: WORD_W] : '0;

    // Both strobes high on a hit is a store.
    assign word_we_c = hit_c & cpu_MemWrite_i;
    assign line_we_c = (state_q == ALLOCATE) & mem_ack_i;

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .idx_i       (sram_idx_c),
        .valid_o     (sram_valid),
        .dirty_o     (sram_dirty),
        .tag_o       (sram_tag),
        .line_o      (sram_line),
        .line_we_i   (line_we_c),
        .line_tag_i  (req_tag_q),
        .line_data_i (mem_data_i),
        .word_we_i   (word_we_c),
        .word_sel_i  (addr_c.word),
        .word_data_i (cpu_data_i)
    );

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (miss_c) state_d = (sram_valid & sram_dirty) ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
            ALLOCATE:  if (mem_ack_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Memory-side outputs are loaded on state transitions and held in between.
    always_comb begin
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        case (state_q)
            IDLE: begin
                if (miss_c) begin
                    mem_enable_d = 1'b1;
                    req_tag_d    = addr_c.tag;
                    req_idx_d    = addr_c.index;
                    if (sram_valid & sram_dirty) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = line_addr(sram_tag, addr_c.index);
                        mem_data_d  = sram_line;
                    end else begin
                        mem_write_d = 1'b0;
                        mem_addr_d  = line_addr(addr_c.tag, addr_c.index);
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    mem_write_d = 1'b0;
                    mem_addr_d  = line_addr(req_tag_q, req_idx_q);
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                end
            end
            default: begin
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
        end else begin
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            req_tag_q    <= req_tag_d;
            req_idx_q    <= req_idx_d;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Data-cache controller for the MEM stage. It answers the pipeline's load/store requests and produces the memory stall that freezes the MEM/WB register.
- Direct-mapped, write-back, write-allocate, 1-word CPU port, 256-bit line port to off-chip data memory.
- Sits between EX/MEM outputs and the off-chip memory model. cpu_stall_o drives the pipeline freeze (MEM/WB hold enable, PC/IF/ID/ID/EX/EX/MEM hold).

Parameters:
- NUM_LINES, 16, number of cache lines; index width = log2(NUM_LINES) = 4.
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset width 5.
- TAG_W, 23, tag width = 32 - 4 - 5.

Ports:
- clk_i  in  1  clock, all state updates on posedge.
- start_i  in  1  reset, asynchronous, active-low.
- cpu_MemRead_i  in  1  load request from EX/MEM.
- cpu_MemWrite_i  in  1  store request from EX/MEM.
- cpu_addr_i  in  32  byte address; bits [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data, valid in the cycle cpu_stall_o=0 with MemRead=1.
- cpu_stall_o  out  1  freeze pipeline (combinational).
- mem_data_i  in  256  refill line from memory.
- mem_ack_i  in  1  one-cycle pulse: memory finished the current request.
- mem_enable_o  out  1  memory request, held until ack.
- mem_write_o  out  1  1 = write-back, 0 = line read.
- mem_addr_o  out  32  line-aligned address, [4:0]=0.
- mem_data_o  out  256  victim line for write-back.

Behaviour:
- Address split: tag=[31:9], index=[8:5], word=[4:2].
- Per-line state: valid, dirty, tag, 256-bit data.
- Reset (start_i low, any time, including mid-miss):
  - all valid and dirty bits cleared; data contents don't-care.
  - FSM to IDLE.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0.
  - cpu_stall_o follows its equation. A late mem_ack_i after reset is ignored.
- req = MemRead|MemWrite. If both are high, the request is treated as a write.
- hit = req & valid[index] & (tag[index]==addr tag) & state==IDLE.
- cpu_stall_o = req & ~hit, purely combinational. It is never asserted when req=0.
- Read hit:
  - cpu_data_o = selected word of the indexed line, same cycle.
  - zero latency, no state change.
- Write hit:
  - at posedge, the selected word is replaced with cpu_data_o's source cpu_data_i; dirty=1.
  - other 7 words unchanged; no stall.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - on req & miss: if valid & dirty -> WRITEBACK, else -> ALLOCATE.
  - the next-state registers load mem outputs on the transition edge.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o={stored tag, index, 5'b0}, mem_data_o=stored line.
  - on mem_ack_i -> ALLOCATE; the line stays valid/dirty until the refill overwrites it.
- ALLOCATE:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}.
  - on mem_ack_i: line=mem_data_i, tag=req tag, valid=1, dirty=0; -> IDLE.
- The cycle after the refill is a hit: a read returns the word, a write merges and sets dirty; stall drops in that cycle.
- Miss latency = ack latency (+ write-back ack latency if dirty) + 1 hit cycle.
- mem_enable_o is registered: it rises the edge after the miss is detected and falls on the edge that samples mem_ack_i. It is never high in IDLE.
- The request inputs must stay stable while stalled. The controller latches nothing from the CPU except on the WRITEBACK/ALLOCATE entry edge (tag/index captured).
- mem_ack_i in IDLE is ignored.
- Index wrap: addresses differing only in tag map to the same line; only a conflict with a dirty victim forces WRITEBACK.

Decomposition:
- Shared header/package dcache_defs:
  - field widths and positions (TAG_W, INDEX_W=4, OFFSET_W=5, WORD_SEL range).
  - FSM state encodings (IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2).
  - LINE_BITS.
- One sub-module, dcache_sram:
  - tag/valid/dirty and data arrays.
  - asynchronous read, synchronous write with word-enable merge, asynchronous clear on start_i.
- The controller holds the FSM, hit logic and memory interface.

Test Plan:
- Cold read: reset, MemRead addr 0x0000_0104, memory returns line with word1=0xDEADBEEF after 10 cycles -> stall high 11 cycles, one ALLOCATE request at mem_addr_o 0x100, then cpu_data_o=0xDEADBEEF, stall 0.
- Write hit: after the above, MemWrite addr 0x108 data 0x12345678 -> no stall; a following read of 0x108 returns 0x12345678 with zero stall; dirty set.
- Dirty eviction: read 0x0000_0308 (same index 8, new tag) -> WRITEBACK to 0x100 with mem_data_o word2=0x12345678 and word1=0xDEADBEEF, then ALLOCATE at 0x300, then hit.
- Clean eviction: conflict on a clean line -> no WRITEBACK, mem_write_o stays 0 throughout.
- Reset mid-ALLOCATE: drop start_i before ack -> mem_enable_o=0 immediately, all lines invalid; a stale ack is ignored; the next read of the same address misses again.
- Read+Write both high on a hit -> handled as a store: word updated, dirty=1, no stall.
